iir_biquad_mc: RTL and testbench

//  Parametrised, multi-channel, time-multiplexed second-order IIR (biquad) filter; successor to the single-channel fixed-12-bit filter.
//  Per-sample channel tag selects one of NCH independent state sets; coefficients are shared and loaded via strobe.

---
 rtl/iir_biquad_mc_pkg.sv | 30 +++
 rtl/iir_biquad_mc_if.sv | 39 +++
 rtl/iir_biquad_mc_mac.sv | 74 +++++++
 rtl/iir_biquad_mc.sv | 131 +++++++++++++
 tb/tb_iir_biquad_mc.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/iir_biquad_mc_pkg.sv
// ---------------------------------------------------------------------------
// iir_pkg
// Shared definitions for the multi-channel biquad filter: default geometry,
// width helpers and the per-channel history record.
// ---------------------------------------------------------------------------
package iir_pkg;

  localparam int NB_DEF   = 12;  // sample / coefficient width
  localparam int FRAC_DEF = 11;  // coefficient fractional bits (Q1.11)
  localparam int NCH_DEF  = 4;   // channel count

  // Accumulator width: 2*nb-bit products plus headroom for five taps.
  function automatic int acc_w(input int nb);
    return 2 * nb + 3;
  endfunction

  // Channel tag width, never narrower than one bit.
  function automatic int cw(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

  // History of one channel at the default sample width.
  typedef struct packed {
    logic signed [NB_DEF-1:0] x1;
    logic signed [NB_DEF-1:0] x2;
    logic signed [NB_DEF-1:0] y1;
    logic signed [NB_DEF-1:0] y2;
  } hist_t;

endpackage

// File: rtl/iir_biquad_mc_if.sv
// ---------------------------------------------------------------------------
// iir_biquad_mc_if
// Sample/coefficient bus between a stimulus source (master) and the filter
// (slave).
//   source -> filter : vIn, dIn, chIn, clrIn, ldCoef, b {b2,b1,b0}, a {a2,a1}
//   filter -> sink   : vOut, dOut, chOut, ovf, err
// ---------------------------------------------------------------------------
interface iir_biquad_mc_if
  import iir_pkg::*;
#(
  parameter int NB = NB_DEF,
  parameter int CW = cw(NCH_DEF)
);

  logic            vIn;
  logic [NB-1:0]   dIn;
  logic [CW-1:0]   chIn;
  logic            clrIn;
  logic            ldCoef;
  logic [3*NB-1:0] b;
  logic [2*NB-1:0] a;

  logic            vOut;
  logic [NB-1:0]   dOut;
  logic [CW-1:0]   chOut;
  logic            ovf;
  logic            err;

  modport master (
    output vIn, dIn, chIn, clrIn, ldCoef, b, a,
    input  vOut, dOut, chOut, ovf, err
  );

  modport slave (
    input  vIn, dIn, chIn, clrIn, ldCoef, b, a,
    output vOut, dOut, chOut, ovf, err
  );

endinterface

// File: rtl/iir_biquad_mc_mac.sv
// ---------------------------------------------------------------------------
// iir_mac
// Combinational five-tap signed MAC for one biquad step:
//   y = (b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) >>> FRAC
// truncated toward -inf, then reduced to NB bits.
// Build option SATURATE_EN: clamp to the NB-bit range and flag o_ovf;
// otherwise keep the low NB bits (wrap) and tie o_ovf low.
// Ports: i_x..i_y2 samples/history, i_b0..i_a2 coefficients,
//        o_y result, o_ovf clamp flag.
// ---------------------------------------------------------------------------
module iir_mac
  import iir_pkg::*;
#(
  parameter int NB   = NB_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [NB-1:0] i_x,
  input  logic signed [NB-1:0] i_x1,
  input  logic signed [NB-1:0] i_x2,
  input  logic signed [NB-1:0] i_y1,
  input  logic signed [NB-1:0] i_y2,
  input  logic signed [NB-1:0] i_b0,
  input  logic signed [NB-1:0] i_b1,
  input  logic signed [NB-1:0] i_b2,
  input  logic signed [NB-1:0] i_a1,
  input  logic signed [NB-1:0] i_a2,
  output logic signed [NB-1:0] o_y,
  output logic                 o_ovf
);

  localparam int AW = acc_w(NB);

  logic signed [2*NB-1:0] w_p0, w_p1, w_p2, w_p3, w_p4;
  logic signed [AW-1:0]   w_acc;

  assign w_p0 = i_b0 * i_x;
  assign w_p1 = i_b1 * i_x1;
  assign w_p2 = i_b2 * i_x2;
  assign w_p3 = i_a1 * i_y1;
  assign w_p4 = i_a2 * i_y2;

  // Products are sign-extended before summing so the feedback subtraction
  // cannot wrap inside the accumulator.
  assign w_acc = AW'(w_p0) + AW'(w_p1) + AW'(w_p2) - AW'(w_p3) - AW'(w_p4);

`ifdef SATURATE_EN
  localparam logic signed [AW-1:0] Y_MAX = {{(AW-NB+1){1'b0}}, {(NB-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {{(AW-NB+1){1'b1}}, {(NB-1){1'b0}}};

  logic signed [AW-1:0] w_shift;
  assign w_shift = w_acc >>> FRAC;

  // NOTE: every output gets a default at the top of the block; a path that
  // skipped an assignment would infer a latch.
  always_comb begin
    o_y   = w_shift[NB-1:0];
    o_ovf = 1'b0;
    if (w_shift > Y_MAX) begin
      o_y   = Y_MAX[NB-1:0];
      o_ovf = 1'b1;
    end else if (w_shift < Y_MIN) begin
      o_y   = Y_MIN[NB-1:0];
      o_ovf = 1'b1;
    end
  end
`else
  // Wrap: the NB bits just above the fraction are the result.
  logic w_unused;
  assign w_unused = ^{w_acc[AW-1:FRAC+NB], w_acc[FRAC-1:0]};
  assign o_y      = w_acc[FRAC +: NB];
  assign o_ovf    = 1'b0;
`endif

endmodule

// File: rtl/iir_biquad_mc.sv
// ---------------------------------------------------------------------------
// iir_biquad_mc
// Time-multiplexed multi-channel biquad. Each accepted sample selects one of
// NCH history sets by its channel tag; coefficients are shared and loaded by
// strobe. Single-cycle MAC, registered outputs (latency one edge).
// Build option: SATURATE_EN (clamp + ovf) vs. default wrap (ovf tied 0).
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset, overrides everything
//   bus  - iir_biquad_mc_if.slave: vIn/dIn/chIn/clrIn/ldCoef/b/a in,
//          vOut/dOut/chOut/ovf/err out
// ---------------------------------------------------------------------------
module iir_biquad_mc
  import iir_pkg::*;
#(
  parameter int NB   = NB_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int NCH  = NCH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  iir_biquad_mc_if.slave    bus
);

  localparam int CW = cw(NCH);

  typedef struct packed {
    logic signed [NB-1:0] x1;
    logic signed [NB-1:0] x2;
    logic signed [NB-1:0] y1;
    logic signed [NB-1:0] y2;
  } chan_hist_t;

  chan_hist_t      r_hist [NCH];
  logic [3*NB-1:0] r_b;
  logic [2*NB-1:0] r_a;

  logic            r_vout;
  logic [NB-1:0]   r_dout;
  logic [CW-1:0]   r_chout;
  logic            r_ovf;
  logic            r_err;

  logic              w_ch_ok;
  logic              w_accept;
  chan_hist_t        w_h;
  logic signed [NB-1:0] w_y;
  logic              w_ovf;

  // A full power-of-two channel space has no illegal tags.
  generate
    if (NCH == (1 << CW)) begin : g_ch_full
      assign w_ch_ok = 1'b1;
    end else begin : g_ch_range
      assign w_ch_ok = ({1'b0, bus.chIn} < (CW+1)'(NCH));
    end
  endgenerate

  assign w_accept = bus.vIn & w_ch_ok;

  // Clear takes effect before the sample is computed.
  assign w_h = bus.clrIn ? '0 : r_hist[bus.chIn];

  iir_mac #(
    .NB   (NB),
    .FRAC (FRAC)
  ) u_mac (
    .i_x   ($signed(bus.dIn)),
    .i_x1  (w_h.x1),
    .i_x2  (w_h.x2),
    .i_y1  (w_h.y1),
    .i_y2  (w_h.y2),
    .i_b0  ($signed(r_b[0*NB +: NB])),
    .i_b1  ($signed(r_b[1*NB +: NB])),
    .i_b2  ($signed(r_b[2*NB +: NB])),
    .i_a1  ($signed(r_a[0*NB +: NB])),
    .i_a2  ($signed(r_a[1*NB +: NB])),
    .o_y   (w_y),
    .o_ovf (w_ovf)
  );

  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b     <= '0;
      r_a     <= '0;
      r_vout  <= 1'b0;
      r_dout  <= '0;
      r_chout <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      // NOTE: the history is a small flop array, not a RAM, so it can and
      // must be cleared by reset; a RAM-mapped store could not be.
      for (int i = 0; i < NCH; i++) r_hist[i] <= '0;
    end else begin
      if (bus.ldCoef) begin
        r_b <= bus.b;
        r_a <= bus.a;
      end

      if (bus.clrIn) begin
        for (int i = 0; i < NCH; i++) r_hist[i] <= '0;
      end

      // Written after the clear loop so the accepted channel keeps its
      // fresh x1/y1 when both happen on the same edge.
      if (w_accept) begin
        r_hist[bus.chIn] <= chan_hist_t'{
          x1: $signed(bus.dIn),
          x2: w_h.x1,
          y1: w_y,
          y2: w_h.y1
        };
        r_dout  <= w_y;
        r_chout <= bus.chIn;
      end

      r_vout <= w_accept;
      r_ovf  <= w_accept & w_ovf;
      r_err  <= bus.vIn & ~w_ch_ok;
    end
  end

  assign bus.vOut  = r_vout;
  assign bus.dOut  = r_dout;
  assign bus.chOut = r_chout;
  assign bus.ovf   = r_ovf;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_iir_biquad_mc.sv
// ---------------------------------------------------------------------------
// tb_iir_biquad_mc
// Bench for iir_biquad_mc at NB=12, FRAC=11, NCH=3. A table of hand-derived
// vectors covers gain, feedback, channel isolation, overflow, illegal
// channel, clear-with-sample and coefficient-load timing; a hand-written
// reset-mid-stream sequence follows; then randomized traffic is compared
// against an integer reference model. Honours SATURATE_EN like the design.
// ---------------------------------------------------------------------------
module tb_iir_biquad_mc;
  import iir_pkg::*;

  localparam int NB   = 12;
  localparam int FRAC = 11;
  localparam int NCH  = 3;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic rst;

  iir_biquad_mc_if #(.NB(NB), .CW(CW)) bif ();

  iir_biquad_mc #(
    .NB   (NB),
    .FRAC (FRAC),
    .NCH  (NCH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] d, input logic [1:0] ch,
                       input logic clr, input logic ld,
                       input logic [35:0] b, input logic [23:0] a);
    bif.vIn    = v;
    bif.dIn    = d;
    bif.chIn   = ch;
    bif.clrIn  = clr;
    bif.ldCoef = ld;
    bif.b      = b;
    bif.a      = a;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [11:0] ed,
                           input logic [1:0] ech, input logic eovf, input logic eerr);
    check({tag, ".vOut"},  32'(bif.vOut),  32'(ev));
    check({tag, ".dOut"},  32'(bif.dOut),  32'(ed));
    check({tag, ".chOut"}, 32'(bif.chOut), 32'(ech));
    check({tag, ".ovf"},   32'(bif.ovf),   32'(eovf));
    check({tag, ".err"},   32'(bif.err),   32'(eerr));
  endtask

  // ---------------- reference model (integer arithmetic) ----------------
  hist_t       m_h [NCH];
  int          m_b [3];
  int          m_a [2];
  logic        e_v, e_ovf, e_err;
  logic [11:0] e_d;
  logic [1:0]  e_ch;

  function automatic int sx12(input logic [11:0] v);
    return (v >= 12'h800) ? int'(v) - 4096 : int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_h[i] = '0;
    m_b = '{0, 0, 0};
    m_a = '{0, 0};
    e_v = 0; e_d = '0; e_ch = '0; e_ovf = 0; e_err = 0;
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [11:0] d,
                            input logic [1:0] ch, input logic clr, input logic ld,
                            input logic [35:0] b, input logic [23:0] a);
    longint acc, q, y;
    hist_t  h;
    if (r) begin
      model_reset();
      return;
    end
    e_v = 0; e_ovf = 0; e_err = 0;
    y = 0;
    h = '0;
    if (v && ch >= NCH) e_err = 1;
    if (v && ch < NCH) begin
      h = clr ? hist_t'('0) : m_h[ch];
      acc = longint'(m_b[0]) * sx12(d)
          + longint'(m_b[1]) * longint'(h.x1)
          + longint'(m_b[2]) * longint'(h.x2)
          - longint'(m_a[0]) * longint'(h.y1)
          - longint'(m_a[1]) * longint'(h.y2);
      q = acc >>> FRAC;
`ifdef SATURATE_EN
      if (q > 2047)       begin y = 2047;  e_ovf = 1; end
      else if (q < -2048) begin y = -2048; e_ovf = 1; end
      else                y = q;
`else
      y = ((q % 4096) + 4096) % 4096;
      if (y >= 2048) y -= 4096;
`endif
    end
    if (clr) for (int i = 0; i < NCH; i++) m_h[i] = '0;
    if (v && ch < NCH) begin
      m_h[ch].x2 = h.x1;
      m_h[ch].x1 = 12'(sx12(d));
      m_h[ch].y2 = h.y1;
      m_h[ch].y1 = 12'(y);
      e_v  = 1;
      e_d  = 12'(y);
      e_ch = ch;
    end
    if (ld) begin
      m_b[0] = sx12(b[11:0]);  m_b[1] = sx12(b[23:12]); m_b[2] = sx12(b[35:24]);
      m_a[0] = sx12(a[11:0]);  m_a[1] = sx12(a[23:12]);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [11:0] d;
    logic [1:0]  ch;
    logic        clr;
    logic        ld;
    logic [35:0] b;
    logic [23:0] a;
    logic        ev;
    logic [11:0] ed;
    logic [1:0]  ech;
    logic        eovf;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [11:0] d, input logic [1:0] ch,
                              input logic clr, input logic ld,
                              input logic [35:0] b, input logic [23:0] a,
                              input logic ev, input logic [11:0] ed, input logic [1:0] ech,
                              input logic eovf, input logic eerr);
    vec_t t;
    t.v = v; t.d = d; t.ch = ch; t.clr = clr; t.ld = ld; t.b = b; t.a = a;
    t.ev = ev; t.ed = ed; t.ech = ech; t.eovf = eovf; t.eerr = eerr;
    return t;
  endfunction

  localparam logic [35:0] B_GAIN = {12'h000, 12'h000, 12'h400};
  localparam logic [35:0] B_OVF  = {12'h000, 12'h7FF, 12'h7FF};
  localparam logic [23:0] A_ZERO = 24'h000000;
  localparam logic [23:0] A_FB   = {12'h000, 12'hC00};

`ifdef SATURATE_EN
  localparam logic [11:0] OVF_D = 12'h7FF;
  localparam logic        OVF_F = 1'b1;
`else
  localparam logic [11:0] OVF_D = 12'hFFC;
  localparam logic        OVF_F = 1'b0;
`endif

  vec_t tbl [18];

  initial begin
    // gain
    tbl[0]  = mk(0, 12'h000, 0, 0, 1, B_GAIN, A_ZERO, 0, 12'h000, 0, 0, 0);
    tbl[1]  = mk(1, 12'h200, 0, 0, 0, '0,     '0,     1, 12'h100, 0, 0, 0);
    // feedback on ch0 interleaved with silent ch1
    tbl[2]  = mk(0, 12'h000, 0, 1, 1, B_GAIN, A_FB,   0, 12'h100, 0, 0, 0);
    tbl[3]  = mk(1, 12'h7FE, 0, 0, 0, '0,     '0,     1, 12'h3FF, 0, 0, 0);
    tbl[4]  = mk(1, 12'h000, 1, 0, 0, '0,     '0,     1, 12'h000, 1, 0, 0);
    tbl[5]  = mk(1, 12'h000, 0, 0, 0, '0,     '0,     1, 12'h1FF, 0, 0, 0);
    tbl[6]  = mk(1, 12'h000, 1, 0, 0, '0,     '0,     1, 12'h000, 1, 0, 0);
    tbl[7]  = mk(1, 12'h000, 0, 0, 0, '0,     '0,     1, 12'h0FF, 0, 0, 0);
    // illegal channel: dropped, outputs hold, history untouched
    tbl[8]  = mk(1, 12'h123, 3, 0, 0, '0,     '0,     0, 12'h0FF, 0, 0, 1);
    tbl[9]  = mk(1, 12'h000, 0, 0, 0, '0,     '0,     1, 12'h07F, 0, 0, 0);
    // clear together with a sample
    tbl[10] = mk(1, 12'h7FE, 0, 1, 0, '0,     '0,     1, 12'h3FF, 0, 0, 0);
    tbl[11] = mk(1, 12'h000, 0, 0, 0, '0,     '0,     1, 12'h1FF, 0, 0, 0);
    // overflow on ch2
    tbl[12] = mk(0, 12'h000, 0, 1, 1, B_OVF,  A_ZERO, 0, 12'h1FF, 0, 0, 0);
    tbl[13] = mk(1, 12'h7FF, 2, 0, 0, '0,     '0,     1, 12'h7FE, 2, 0, 0);
    tbl[14] = mk(1, 12'h7FF, 2, 0, 0, '0,     '0,     1, OVF_D,   2, OVF_F, 0);
    tbl[15] = mk(0, 12'h000, 0, 0, 0, '0,     '0,     0, OVF_D,   2, 0, 0);
    // load in the same cycle as a sample: old coefficients still apply
    tbl[16] = mk(1, 12'h200, 1, 0, 1, B_GAIN, A_ZERO, 1, 12'h1FF, 1, 0, 0);
    tbl[17] = mk(1, 12'h200, 1, 0, 0, '0,     '0,     1, 12'h100, 1, 0, 0);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic        r_v, r_clr, r_ld, r_rst;
    logic [11:0] r_d;
    logic [1:0]  r_ch;
    logic [35:0] r_b;
    logic [23:0] r_a;

    rst = 1'b1;
    drive(0, '0, '0, 0, 0, '0, '0);
    repeat (2) tick();

    check_out("reset", 0, 12'h000, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].ch, tbl[i].clr, tbl[i].ld, tbl[i].b, tbl[i].a);
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ech, tbl[i].eovf, tbl[i].eerr);
    end

    // Reset mid-stream: coefficients and history must be gone afterwards.
    drive(0, '0, '0, 1, 1, B_GAIN, A_FB);
    tick();
    drive(1, 12'h7FE, 0, 0, 0, '0, '0);
    tick();
    check_out("rst_pre", 1, 12'h3FF, 0, 0, 0);
    rst = 1'b1;
    drive(1, 12'h000, 1, 0, 0, '0, '0);
    tick();
    check_out("rst_mid", 0, 12'h000, 0, 0, 0);
    rst = 1'b0;
    drive(1, 12'h7FE, 0, 0, 0, '0, '0);
    tick();
    check_out("rst_zero_coef", 1, 12'h000, 0, 0, 0);
    drive(0, '0, '0, 0, 1, B_GAIN, A_FB);
    tick();
    drive(1, 12'h7FE, 0, 0, 0, '0, '0);
    tick();
    check_out("rst_reload", 1, 12'h3FF, 0, 0, 0);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    drive(0, '0, '0, 0, 0, '0, '0);
    tick();
    model_reset();
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_d   = 12'($urandom);
      r_ch  = 2'($urandom_range(0, 3));
      r_clr = ($urandom_range(0, 19) == 0);
      r_ld  = (n == 0) || ($urandom_range(0, 15) == 0);
      r_b   = {12'($urandom), 12'($urandom), 12'($urandom)};
      r_a   = {12'($urandom), 12'($urandom)};
      // Keep the feedback moderate most of the time so long runs stay in range.
      if ($urandom_range(0, 3) != 0) r_a = {12'($urandom_range(0, 511) - 256), 12'($urandom_range(0, 1023) - 512)};
      rst = r_rst;
      drive(r_v, r_d, r_ch, r_clr, r_ld, r_b, r_a);
      model_edge(r_rst, r_v, r_d, r_ch, r_clr, r_ld, r_b, r_a);
      tick();
      check_out($sformatf("rnd%0d", n), e_v, e_d, e_ch, e_ovf, e_err);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
